// File: rtl/da_idct8_row.sv
// Distributed-arithmetic 8-point row IDCT: bit-serial MSB-first over the coefficient bits,
// then eight serialized samples x0..x7. Define DA_IDCT_SAT_EN to clamp outputs instead of wrapping.
module da_idct8_row #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 34
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [8*DATA_W-1:0]        in_coef,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [DATA_W-1:0]   out_sample,
    output logic [2:0]                 out_index,
    output logic                       out_last
);
    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] BIT_MSB = BIT_W'(DATA_W - 1);
    localparam int FRAC = 14;
    localparam logic signed [ACC_W-1:0] RND  = ACC_W'(1 << (FRAC - 1));
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

    // 0.5*C_k*cos terms scaled by 2^30; entries are rounded to Q2.14 after summing.
    localparam longint T_A  = 379625062;
    localparam longint T_C2 = 496004047;
    localparam longint T_C6 = 205451603;
    localparam longint T_D1 = 526555088;
    localparam longint T_D3 = 446391850;
    localparam longint T_D5 = 298269498;
    localparam longint T_D7 = 104738319;

    // i = lut*4 + k; luts 0..3 are even n=0..3 (Z0,Z2,Z4,Z6), 4..7 odd n=0..3 (Z1,Z3,Z5,Z7)
    function automatic longint term(input int i);
        case (i)
            0:  return  T_A;   1: return  T_C2;  2: return  T_A;   3: return  T_C6;
            4:  return  T_A;   5: return  T_C6;  6: return -T_A;   7: return -T_C2;
            8:  return  T_A;   9: return -T_C6; 10: return -T_A;  11: return  T_C2;
            12: return  T_A;  13: return -T_C2; 14: return  T_A;  15: return -T_C6;
            16: return  T_D1; 17: return  T_D3; 18: return  T_D5; 19: return  T_D7;
            20: return  T_D3; 21: return -T_D7; 22: return -T_D1; 23: return -T_D5;
            24: return  T_D5; 25: return -T_D1; 26: return  T_D7; 27: return  T_D3;
            28: return  T_D7; 29: return -T_D5; 30: return  T_D3; 31: return -T_D1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [8*16*COEF_W-1:0] build_luts();
        logic [8*16*COEF_W-1:0] f;
        longint s;
        longint r;
        f = '0;
        for (int lut = 0; lut < 8; lut++) begin
            for (int a = 0; a < 16; a++) begin
                s = 0;
                for (int k = 0; k < 4; k++)
                    if (a[k]) s = s + term(lut * 4 + k);
                r = (s + 64'sd32768) >>> 16;
                f[(lut*16 + a)*COEF_W +: COEF_W] = r[COEF_W-1:0];
            end
        end
        return f;
    endfunction

    localparam logic [8*16*COEF_W-1:0] LUT_FLAT = build_luts();

    function automatic logic signed [COEF_W-1:0] lut_rd(input int lut, input logic [3:0] a);
        return LUT_FLAT[(lut*16 + int'(a))*COEF_W +: COEF_W];
    endfunction

    function automatic logic signed [DATA_W-1:0] shape(input logic signed [ACC_W-1:0] e,
                                                       input logic signed [ACC_W-1:0] o,
                                                       input logic                    neg);
        logic signed [ACC_W-1:0] s;
        logic signed [ACC_W-1:0] r;
        s = neg ? e - o : e + o;
        r = (s + RND) >>> FRAC;
`ifdef DA_IDCT_SAT_EN
        if (r > SMAX) r = SMAX;
        else if (r < SMIN) r = SMIN;
`endif
        return r[DATA_W-1:0];
    endfunction

    state_t                    state_q, state_d;
    logic [8*DATA_W-1:0]       coef_q, coef_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic signed [ACC_W-1:0]   acc_q [8];
    logic signed [ACC_W-1:0]   acc_d [8];
    logic [2:0]                idx_q, idx_d;
    logic                      valid_q, valid_d;
    logic                      last_q, last_d;
    logic signed [DATA_W-1:0]  sample_q, sample_d;
    logic [3:0]                a_even, a_odd;
    logic [1:0]                pair;

    assign a_even = {coef_q[6*DATA_W + int'(bit_q)], coef_q[4*DATA_W + int'(bit_q)],
                     coef_q[2*DATA_W + int'(bit_q)], coef_q[int'(bit_q)]};
    assign a_odd  = {coef_q[7*DATA_W + int'(bit_q)], coef_q[5*DATA_W + int'(bit_q)],
                     coef_q[3*DATA_W + int'(bit_q)], coef_q[DATA_W + int'(bit_q)]};

    always_comb begin
        state_d = state_q;
        coef_d  = coef_q;
        bit_d   = bit_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    coef_d  = in_coef;
                    bit_d   = BIT_MSB;
                    for (int j = 0; j < 8; j++) acc_d[j] = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                // The MSB slice carries negative weight in two's complement.
                for (int j = 0; j < 8; j++) begin
                    if (bit_q == BIT_MSB)
                        acc_d[j] = -ACC_W'(lut_rd(j, (j < 4) ? a_even : a_odd));
                    else
                        acc_d[j] = (acc_q[j] <<< 1) + ACC_W'(lut_rd(j, (j < 4) ? a_even : a_odd));
                end
                if (bit_q == '0) begin
                    state_d = OUTPUT;
                    valid_d = 1'b1;
                    idx_d   = 3'd0;
                    last_d  = 1'b0;
                end else begin
                    bit_d = bit_q - 1'b1;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    if (idx_q == 3'd7) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        last_d = (idx_q == 3'd6);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Samples 4..7 mirror pairs 3..0 with the odd part subtracted.
        pair     = idx_d[2] ? ~idx_d[1:0] : idx_d[1:0];
        sample_d = shape(acc_d[pair], acc_d[4 + int'(pair)], idx_d[2]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            coef_q   <= '0;
            bit_q    <= '0;
            for (int j = 0; j < 8; j++) acc_q[j] <= '0;
            idx_q    <= 3'd0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            coef_q   <= coef_d;
            bit_q    <= bit_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            sample_q <= sample_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = valid_q;
    assign out_sample = sample_q;
    assign out_index  = idx_q;
    assign out_last   = last_q;
endmodule

// File: tb/tb_da_idct8_row.sv
// Directed bench for da_idct8_row; expected samples come from a $cos-derived LUT and a bit-weight DA model.
module tb_da_idct8_row;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [8*DATA_W-1:0] in_coef = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic signed [DATA_W-1:0] out_sample;
    logic [2:0] out_index;
    logic out_last;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int lut_e [4][16];
    int lut_o [4][16];

    da_idct8_row dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
        .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
        .out_index(out_index), .out_last(out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert ((obs - exp) <= 1 && (exp - obs) <= 1) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d (+-1)", tag, obs, exp);
        end
    endtask

    task automatic build_model();
        real pi, c, se, so;
        int ke, ko;
        pi = 3.14159265358979323846;
        for (int n = 0; n < 4; n++) begin
            for (int a = 0; a < 16; a++) begin
                se = 0.0;
                so = 0.0;
                for (int i = 0; i < 4; i++) begin
                    if (a[i]) begin
                        ke = 2 * i;
                        ko = 2 * i + 1;
                        c = (ke == 0) ? 0.5 / $sqrt(2.0) : 0.5;
                        se = se + c * $cos((2 * n + 1) * ke * pi / 16.0);
                        so = so + 0.5 * $cos((2 * n + 1) * ko * pi / 16.0);
                    end
                end
                lut_e[n][a] = $rtoi($floor(se * 16384.0 + 0.5));
                lut_o[n][a] = $rtoi($floor(so * 16384.0 + 0.5));
            end
        end
    endtask

    function automatic longint model(input logic [8*DATA_W-1:0] c, input int n);
        int p;
        longint e, o, w, s, r;
        logic [3:0] ae, ao;
        logic [15:0] r16;
        p = (n < 4) ? n : 7 - n;
        e = 0;
        o = 0;
        for (int b = 0; b < 16; b++) begin
            ae = {c[96+b], c[64+b], c[32+b], c[b]};
            ao = {c[112+b], c[80+b], c[48+b], c[16+b]};
            w = (b == 15) ? -(64'sd1 <<< 15) : (64'sd1 <<< b);
            e = e + longint'(lut_e[p][ae]) * w;
            o = o + longint'(lut_o[p][ao]) * w;
        end
        s = (n < 4) ? e + o : e - o;
        r = (s + 8192) >>> 14;
`ifdef DA_IDCT_SAT_EN
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
`else
        r16 = r[15:0];
        return longint'($signed(r16));
`endif
    endfunction

    task automatic run_row(input logic [8*DATA_W-1:0] coef, input bit rnd, input bit use_hand,
                           input int hand [8], input string tag);
        int guard, got, t0, first, held_idx;
        bit stalled;
        logic signed [DATA_W-1:0] held;
        @(negedge clk);
        in_coef = coef;
        in_valid = 1'b1;
        out_ready = 1'b0;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, " accept"}, longint'(in_ready), 1);
        t0 = cyc;
        @(negedge clk);
        in_valid = 1'b1;
        in_coef = {$urandom, $urandom, $urandom, $urandom};
        got = 0;
        first = -1;
        guard = 0;
        stalled = 1'b0;
        held = '0;
        held_idx = 0;
        while (got < 8 && guard < 400) begin
            if (out_valid && first < 0) first = cyc;
            if (stalled) begin
                chk({tag, " held sample"}, longint'(out_sample), longint'(held));
                chk({tag, " held index"}, longint'(out_index), longint'(held_idx));
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                chk({tag, " index"}, longint'(out_index), longint'(got));
                chk({tag, " sample"}, longint'(out_sample), model(coef, got));
                chk({tag, " last"}, longint'(out_last), longint'(got == 7));
                chk({tag, " in_ready busy"}, longint'(in_ready), 0);
                if (use_hand) chk_tol({tag, " hand"}, longint'(out_sample), longint'(hand[got]));
                got++;
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1;
                held = out_sample;
                held_idx = int'(out_index);
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk({tag, " sample count"}, longint'(got), 8);
        chk({tag, " latency"}, longint'(first - t0), 17);
        chk({tag, " idle in_ready"}, longint'(in_ready), 1);
        chk({tag, " idle out_valid"}, longint'(out_valid), 0);
    endtask

    initial begin
        int none [8];
        int h1 [8];
        int h2 [8];
        int h3 [8];
        int seen;
        logic [8*DATA_W-1:0] c;
        none = '{0, 0, 0, 0, 0, 0, 0, 0};
        h1 = '{362, 362, 362, 362, 362, 362, 362, 362};
        h2 = '{490, 416, 278, 98, -98, -278, -416, -490};
        h3 = '{924, 383, -383, -924, -924, -383, 383, 924};
        build_model();

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset in_ready", longint'(in_ready), 1);
        chk("reset out_valid", longint'(out_valid), 0);
        chk("reset out_sample", longint'(out_sample), 0);
        chk("reset out_index", longint'(out_index), 0);
        chk("reset out_last", longint'(out_last), 0);

        run_row('0, 1'b0, 1'b1, none, "zero");

        c = '0;
        c[15:0] = 16'd1024;
        run_row(c, 1'b0, 1'b1, h1, "dc1024");

        c = '0;
        c[31:16] = 16'd1000;
        run_row(c, 1'b0, 1'b1, h2, "z1_1000");

        c = {8{16'h8000}};
        run_row(c, 1'b0, 1'b0, none, "allneg");
`ifdef DA_IDCT_SAT_EN
        chk("allneg x0 hand", model(c, 0), -32768);
`else
        chk("allneg x0 hand", model(c, 0), -21032);
`endif

        for (int r = 0; r < 4; r++)
            run_row({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, none, "random");

        @(negedge clk);
        in_coef = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst in_ready", longint'(in_ready), 1);
        chk("midrst out_valid", longint'(out_valid), 0);
        chk("midrst out_sample", longint'(out_sample), 0);
        chk("midrst out_index", longint'(out_index), 0);
        chk("midrst out_last", longint'(out_last), 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst no stale samples", longint'(seen), 0);

        c = '0;
        c[47:32] = 16'd2000;
        run_row(c, 1'b1, 1'b1, h3, "z2_2000");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/da_idct8_row.md
Name: da_idct8_row

Overview:
- Distributed-arithmetic 8-point 1-D inverse DCT.
- Decode-side counterpart of the forward DA DCT coefficient ROMs: takes one row of 8 DCT coefficients Z0..Z7 and reconstructs 8 samples x0..x7.
- Bit-serial over the coefficient bits. Internal even/odd coefficient-sum LUTs use the same Q2.14 two's-complement format as the forward ROMs (0.38268343236 = 6270).
- Sits between the RLE decoder and the column/output stage of the decompression path.

Parameters:
- DATA_W, 16, width of input coefficients and output samples (signed integers).
- COEF_W, 16, LUT entry width, signed Q2.14.
- ACC_W, 34, accumulator width (DATA_W+COEF_W+2).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  coefficient row valid.
- in_ready  output  1  block can accept a row.
- in_coef  input  8*DATA_W  Z0 in bits [DATA_W-1:0] … Z7 in the top DATA_W bits, signed.
- out_valid  output  1  sample valid.
- out_ready  input  1  downstream accepts sample.
- out_sample  output  DATA_W  reconstructed sample, signed.
- out_index  output  3  sample index n (0..7).
- out_last  output  1  high with index 7.

Behaviour:
- Math: x_n = sum_k 0.5*C_k*Z_k*cos((2n+1)kπ/16), with C0=1/√2 and Ck=1 otherwise.
- Decomposition: even part e_n uses Z0,Z2,Z4,Z6; odd part o_n uses Z1,Z3,Z5,Z7.
  - x_n = e_n + o_n for n=0..3.
  - x_(7-n) = e_n − o_n.
- LUTs: 4 even and 4 odd, each 16 entries, addressed by one bit-slice {bit of Z6,Z4,Z2,Z0} (even) or {Z7,Z5,Z3,Z1} (odd).
  - Each entry is the sum of the selected 0.5*C_k*cos terms, rounded to nearest in Q2.14.
  - Address 0 = 0.
- FSM states: IDLE, ACCUM, OUTPUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture in_coef, set bit counter b=DATA_W-1, clear all 8 accumulators, go to ACCUM.
- ACCUM (exactly DATA_W cycles, MSB first):
  - First cycle (sign slice): acc = −LUT.
  - Later cycles: acc = (acc<<1) + LUT.
  - After the cycle with b=0, go to OUTPUT.
- OUTPUT:
  - Compute e_n ± o_n in ACC_W bits.
  - Drop 14 fraction bits with round-half-up: add 2^13, arithmetic shift right 14.
  - Truncate to DATA_W (wrap), unless DA_IDCT_SAT_EN is defined.
  - Present samples in order n=0..7; advance only on out_valid&out_ready; out_sample stable while stalled.
  - After index 7 is accepted, return to IDLE.
- Latency: handshake at cycle T, first out_valid at T+DATA_W+1.
  - Minimum row period: DATA_W+9 cycles with out_ready held high.
- in_ready=0 in ACCUM and OUTPUT. No overlap between rows; a new row is taken only from IDLE.
- Reset (any state, including mid-ACCUM/OUTPUT), next edge:
  - State=IDLE, in_ready=1, out_valid=0, out_sample=0, out_index=0, out_last=0, accumulators cleared.
  - Partial row is discarded, with no further out_valid for it.
- in_valid during ACCUM/OUTPUT is ignored; in_coef is not re-sampled.
- out_ready may toggle arbitrarily; no sample is dropped or duplicated.

Optional Feature:
- DA_IDCT_SAT_EN defined: rounded results outside [−2^(DATA_W−1), 2^(DATA_W−1)−1] clamp to those bounds.
- Not defined: two's-complement wrap to DATA_W bits.
- Rounding is identical in both modes.

Test Plan:
- All Z=0 → 8 samples all 0, indices 0..7, out_last only on index 7, first out_valid 17 cycles after accept.
- Z0=1024, others 0 → all x_n = 362 (1024*0.35355), ±1 LSB LUT tolerance.
- Z1=1000, others 0 → x0=490, x1=416, x2=278, x3=98, x4=−98, x5=−278, x6=−416, x7=−490 (±1).
- Z0=Z1=…=Z7=−32768 with DA_IDCT_SAT_EN → saturated samples at −32768/32767 where exact result overflows; without the macro, wrapped values match a bit-true model.
- Random rows with out_ready toggling randomly → output sequence equals bit-true reference model; out_sample held while stalled; in_ready low until index 7 accepted.
- rst pulsed at ACCUM cycle 5, then new row Z2=2000 → no samples from the aborted row; new row gives x0=924, x3=−924, x4=−924, x7=924 (±1).
